// File: rtl/rf_pkg.sv
// Shared register-file definitions for the write-back path: index width,
// data width, the x0 index and the queued write-back entry type.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] X0 = 5'd0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_fifo.sv
// wb_fifo_2w1r: circular buffer taking up to two writes and one read per
// cycle; exposes count, read pointer and every slot for the query logic.
module wb_fifo_2w1r
    import rf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  wb_entry_t              entry0,
    input  logic                   push1,
    input  wb_entry_t              entry1,
    input  logic                   pop,
    output logic [CW-1:0]          count,
    output logic [PW-1:0]          rd_ptr,
    output wb_entry_t              head,
    output logic [DEPTH-1:0]       valid,
    output wb_entry_t [DEPTH-1:0]  entries
);

    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [DEPTH-1:0]       valid_r;
    wb_entry_t [DEPTH-1:0]  mem_r;
    logic [CW-1:0]          n_push_s;
    logic [PW-1:0]          wr_ptr_p1_s;

    always_comb begin
        n_push_s    = CW'(push0) + CW'(push1);
        wr_ptr_p1_s = wr_ptr_r + PW'(1);
    end

    // Pointer, count and valid bookkeeping; a push into the slot being popped wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= '0;
        end else begin
            if (pop) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PW'(1);
            end
            if (push0 || push1) begin
                valid_r[wr_ptr_r] <= 1'b1;
            end
            if (push0 && push1) begin
                valid_r[wr_ptr_p1_s] <= 1'b1;
            end
            wr_ptr_r <= wr_ptr_r + n_push_s[PW-1:0];
            count_r  <= count_r + n_push_s - CW'(pop);
        end
    end

    // Entry storage; ALU (push0) takes the older slot when both push.
    always_ff @(posedge clk) begin
        if (push0 && push1) begin
            mem_r[wr_ptr_r]    <= entry0;
            mem_r[wr_ptr_p1_s] <= entry1;
        end else if (push0) begin
            mem_r[wr_ptr_r] <= entry0;
        end else if (push1) begin
            mem_r[wr_ptr_r] <= entry1;
        end
    end

    assign count   = count_r;
    assign rd_ptr  = rd_ptr_r;
    assign head    = mem_r[rd_ptr_r];
    assign valid   = valid_r;
    assign entries = mem_r;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register-file write port from ALU and LSU.
// Optional forwarding of the youngest pending value: REGFILE_WB_QUEUE_FWD_EN.
module regfile_wb_queue
    import rf_pkg::*;
#(
    parameter  int WIDTH        = RF_DATA_W,
    parameter  int ADRESS_WIDTH = RF_ADDR_W,
    parameter  int DEPTH        = 4,
    localparam int PW           = $clog2(DEPTH),
    localparam int CW           = PW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADRESS_WIDTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]        alu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [ADRESS_WIDTH-1:0] lsu_rd,
    input  logic [WIDTH-1:0]        lsu_data,
    input  logic                    wb_hold,
    output logic                    we0,
    output logic [ADRESS_WIDTH-1:0] wr_addr0,
    output logic [WIDTH-1:0]        wr_din0,
    input  logic [ADRESS_WIDTH-1:0] rs1_addr,
    input  logic [ADRESS_WIDTH-1:0] rs2_addr,
    output logic                    rs1_pending,
    output logic                    rs2_pending,
    output logic                    rs1_fwd_hit,
    output logic [WIDTH-1:0]        rs1_fwd_data,
    output logic                    rs2_fwd_hit,
    output logic [WIDTH-1:0]        rs2_fwd_data
);

    logic [CW-1:0]          count_s;
    logic [PW-1:0]          rd_ptr_s;
    wb_entry_t              head_s;
    logic [DEPTH-1:0]       valid_s;
    wb_entry_t [DEPTH-1:0]  entries_s;
    logic                   pop_s;
    logic                   push0_s;
    logic                   push1_s;
    logic [CW:0]            free_s;
    wb_entry_t              entry0_s;
    wb_entry_t              entry1_s;

    // Ready only looks at registered occupancy and wb_hold, never at valid.
    always_comb begin
        pop_s     = (count_s != CW'(0)) && !wb_hold;
        free_s    = (CW+1)'(DEPTH) - {1'b0, count_s} + (CW+1)'(pop_s);
        alu_ready = free_s >= (CW+1)'(1);
        lsu_ready = free_s >= (CW+1)'(2);
        push0_s   = alu_valid && alu_ready && (alu_rd != X0);
        push1_s   = lsu_valid && lsu_ready && (lsu_rd != X0);
        entry0_s  = '{rd: alu_rd, data: alu_data};
        entry1_s  = '{rd: lsu_rd, data: lsu_data};
    end

    wb_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0   (push0_s),
        .entry0  (entry0_s),
        .push1   (push1_s),
        .entry1  (entry1_s),
        .pop     (pop_s),
        .count   (count_s),
        .rd_ptr  (rd_ptr_s),
        .head    (head_s),
        .valid   (valid_s),
        .entries (entries_s)
    );

    // Register-file write port driven straight from the registered head.
    always_comb begin
        we0 = pop_s;
        if (count_s != CW'(0)) begin
            wr_addr0 = head_s.rd;
            wr_din0  = head_s.data;
        end else begin
            wr_addr0 = '0;
            wr_din0  = '0;
        end
    end

    // Pending flags cover every valid slot, including the head leaving this cycle.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i] && (entries_s[i].rd == rs1_addr) && (rs1_addr != X0)) begin
                rs1_pending = 1'b1;
            end
            if (valid_s[i] && (entries_s[i].rd == rs2_addr) && (rs2_addr != X0)) begin
                rs2_pending = 1'b1;
            end
        end
    end

`ifdef REGFILE_WB_QUEUE_FWD_EN
    logic [PW-1:0] idx_s;

    // Walk oldest to youngest from the read pointer so the last match is the youngest.
    always_comb begin
        idx_s        = '0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_ptr_s + PW'(k);
            if (valid_s[idx_s] && (entries_s[idx_s].rd == rs1_addr) && (rs1_addr != X0)) begin
                rs1_fwd_data = entries_s[idx_s].data;
            end
            if (valid_s[idx_s] && (entries_s[idx_s].rd == rs2_addr) && (rs2_addr != X0)) begin
                rs2_fwd_data = entries_s[idx_s].data;
            end
        end
        rs1_fwd_hit = rs1_pending;
        rs2_fwd_hit = rs2_pending;
    end
`else
    assign rs1_fwd_hit  = 1'b0;
    assign rs2_fwd_hit  = 1'b0;
    assign rs1_fwd_data = '0;
    assign rs2_fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios then random
// traffic against a queue-based reference model.
module tb_regfile_wb_queue;

    localparam int W = 32;
    localparam int A = 5;
    localparam int D = 4;

    typedef struct {
        logic [A-1:0] rd;
        logic [W-1:0] data;
    } ref_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         alu_valid, alu_ready, lsu_valid, lsu_ready, wb_hold;
    logic [A-1:0] alu_rd, lsu_rd, wr_addr0, rs1_addr, rs2_addr;
    logic [W-1:0] alu_data, lsu_data, wr_din0, rs1_fwd_data, rs2_fwd_data;
    logic         we0, rs1_pending, rs2_pending, rs1_fwd_hit, rs2_fwd_hit;

    int   n_vec  = 0;
    int   n_bad  = 0;
    ref_t q[$];

    always #5 clk = ~clk;

    regfile_wb_queue dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_hold(wb_hold), .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .rs1_fwd_hit(rs1_fwd_hit), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_hit(rs2_fwd_hit), .rs2_fwd_data(rs2_fwd_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; wb_hold = 1'b0;
        alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    function automatic logic pend(input logic [A-1:0] a);
        pend = 1'b0;
        foreach (q[i]) if (a != 0 && q[i].rd == a) pend = 1'b1;
    endfunction

    function automatic logic [W-1:0] youngest(input logic [A-1:0] a);
        youngest = '0;
        foreach (q[i]) if (a != 0 && q[i].rd == a) youngest = q[i].data;
    endfunction

    // Inputs are already applied (at negedge); check outputs, clock once, update model.
    task automatic step();
        logic pop, ar, lr;
        int   free;
        #1;
        pop  = (q.size() != 0) && !wb_hold;
        free = D - q.size() + (pop ? 1 : 0);
        ar   = free >= 1;
        lr   = free >= 2;
        if (!rst) begin
            check_eq("alu_ready", alu_ready, ar);
            check_eq("lsu_ready", lsu_ready, lr);
            check_eq("we0", we0, pop);
            check_eq("wr_addr0", wr_addr0, q.size() != 0 ? q[0].rd : '0);
            check_eq("wr_din0", wr_din0, q.size() != 0 ? q[0].data : '0);
            check_eq("rs1_pending", rs1_pending, pend(rs1_addr));
            check_eq("rs2_pending", rs2_pending, pend(rs2_addr));
`ifdef REGFILE_WB_QUEUE_FWD_EN
            check_eq("rs1_fwd_hit", rs1_fwd_hit, pend(rs1_addr));
            check_eq("rs2_fwd_hit", rs2_fwd_hit, pend(rs2_addr));
            check_eq("rs1_fwd_data", rs1_fwd_data, youngest(rs1_addr));
            check_eq("rs2_fwd_data", rs2_fwd_data, youngest(rs2_addr));
`else
            check_eq("rs1_fwd_hit", rs1_fwd_hit, 1'b0);
            check_eq("rs2_fwd_data", rs2_fwd_data, '0);
`endif
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (alu_valid && ar && alu_rd != 0) q.push_back('{alu_rd, alu_data});
            if (lsu_valid && lr && lsu_rd != 0) q.push_back('{lsu_rd, lsu_data});
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        @(negedge clk);

        // Reset held two cycles with an ALU offer present.
        rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
        step(); step();
        idle(); #1;
        check_eq("rst_we0", we0, 1'b0);
        check_eq("rst_alu_ready", alu_ready, 1'b1);
        check_eq("rst_lsu_ready", lsu_ready, 1'b1);
        check_eq("rst_wr_addr0", wr_addr0, 5'd0);
        step();

        // Single write, one-cycle latency.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1; check_eq("single_no_bypass", we0, 1'b0);
        step(); idle(); #1;
        check_eq("single_we0", we0, 1'b1);
        check_eq("single_addr", wr_addr0, 5'd5);
        check_eq("single_din", wr_din0, 32'hDEADBEEF);
        step(); #1;
        check_eq("single_done", we0, 1'b0);
        step();

        // Dual push to the same register: ALU older than LSU.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h22;
        step(); idle(); #1;
        check_eq("dual_first", wr_din0, 32'h11);
        step(); #1;
        check_eq("dual_second", wr_din0, 32'h22);
        check_eq("dual_second_we", we0, 1'b1);
        step();

        // Fill under hold, then drain in order.
        for (int i = 0; i < D; i++) begin
            wb_hold = 1'b1; alu_valid = 1'b1; alu_rd = A'(i + 10); alu_data = 32'hF00 + i;
            step();
        end
        idle(); wb_hold = 1'b1; #1;
        check_eq("full_alu_ready", alu_ready, 1'b0);
        check_eq("full_lsu_ready", lsu_ready, 1'b0);
        step();
        wb_hold = 1'b0;
        for (int i = 0; i < D; i++) begin
            #1;
            check_eq("drain_we0", we0, 1'b1);
            check_eq("drain_din", wr_din0, 32'hF00 + i);
            step();
        end
        #1; check_eq("drain_empty", we0, 1'b0);
        step();

        // x0 result is accepted and dropped.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        #1; check_eq("x0_ready", alu_ready, 1'b1);
        step(); idle(); #1;
        check_eq("x0_no_write", we0, 1'b0);
        check_eq("x0_pending", rs1_pending, 1'b0);
        step();

        // Forwarding picks the youngest of two writes to the same register.
        wb_hold = 1'b1; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
        step();
        wb_hold = 1'b1; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hB;
        step();
        idle(); wb_hold = 1'b1; rs2_addr = 5'd7; #1;
        check_eq("fwd_pending", rs2_pending, 1'b1);
`ifdef REGFILE_WB_QUEUE_FWD_EN
        check_eq("fwd_hit", rs2_fwd_hit, 1'b1);
        check_eq("fwd_data", rs2_fwd_data, 32'hB);
`else
        check_eq("fwd_hit_off", rs2_fwd_hit, 1'b0);
`endif
        step();

        // Random traffic with register collisions, x0 targets and rare resets.
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(99) == 0);
            wb_hold   = ($urandom_range(9) < 3);
            alu_valid = ($urandom_range(9) < 6);
            lsu_valid = ($urandom_range(9) < 6);
            alu_rd    = A'($urandom_range(7));
            lsu_rd    = A'($urandom_range(7));
            alu_data  = $urandom;
            lsu_data  = $urandom;
            rs1_addr  = A'($urandom_range(7));
            rs2_addr  = A'($urandom_range(7));
            step();
        end

        // Reset mid-burst discards queued entries.
        idle(); wb_hold = 1'b1; alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        step();
        idle(); rst = 1'b1; step();
        idle(); #1;
        check_eq("rst_burst_we0", we0, 1'b0);
        check_eq("rst_burst_pending", rs1_pending, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
